// File: rtl/truth_table_scanner.sv
// Truth-table scanner: holds a 2^N-entry function table, streams every pattern with
// its function value over a valid/ready port, counts ones, and offers single evaluation.
module truth_table_scanner #(
    parameter int          N        = 4,
    parameter logic [63:0] TT_RESET = 64'hAC3C
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [(1<<N)-1:0]   tt_data,
    input  logic                start,
    input  logic                abort,
    input  logic                out_ready,
    input  logic [N-1:0]        eval_vec,
    output logic                busy,
    output logic                out_valid,
    output logic [N-1:0]        out_vec,
    output logic                out_s,
    output logic [N:0]          ones_cnt,
    output logic                done,
    output logic                eval_s
);
    localparam int         W        = 1 << N;
    localparam logic [N:0] ONES_MAX = (N+1)'(W);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SWEEP = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]   state_reg;
    logic [W-1:0] table_reg;
    logic [N-1:0] cnt_reg;
    logic [N:0]   ones_reg;
    logic         eval_s_reg;
    logic         accept;
    logic         last_beat;
    logic         cur_s;

    assign accept    = (state_reg == SWEEP) && out_ready;
    assign last_beat = (cnt_reg == {N{1'b1}});
    assign cur_s     = table_reg[cnt_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            table_reg  <= TT_RESET[W-1:0];
            cnt_reg    <= '0;
            ones_reg   <= '0;
            eval_s_reg <= 1'b0;
        end else begin
            eval_s_reg <= table_reg[eval_vec];
            case (state_reg)
                IDLE: begin
                    // Loading and starting together: the next cycle already reads the new table.
                    if (load) table_reg <= tt_data;
                    if (start) begin
                        state_reg <= SWEEP;
                        cnt_reg   <= '0;
                        ones_reg  <= '0;
                    end
                end
                SWEEP: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cur_s && ones_reg != ONES_MAX) ones_reg <= ones_reg + 1'b1;
                    end
                    // An abort coinciding with the final beat still ends without a done pulse.
                    if (abort)
                        state_reg <= IDLE;
                    else if (accept && last_beat)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == SWEEP);
    assign out_vec   = (state_reg == SWEEP) ? cnt_reg : '0;
    assign out_s     = (state_reg == SWEEP) ? cur_s : 1'b0;
    assign ones_cnt  = ones_reg;
    assign done      = (state_reg == DONE);
    assign eval_s    = eval_s_reg;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner (N=4): evaluation vectors, directed sweeps,
// and randomized sweeps checked against a prefix-popcount reference model.
module tb_truth_table_scanner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] tt_data;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [3:0]  eval_vec;
    logic        busy;
    logic        out_valid;
    logic [3:0]  out_vec;
    logic        out_s;
    logic [4:0]  ones_cnt;
    logic        done;
    logic        eval_s;

    int checks = 0;
    int errors = 0;

    truth_table_scanner #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .tt_data(tt_data), .start(start),
        .abort(abort), .out_ready(out_ready), .eval_vec(eval_vec), .busy(busy),
        .out_valid(out_valid), .out_vec(out_vec), .out_s(out_s), .ones_cnt(ones_cnt),
        .done(done), .eval_s(eval_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] tt;
        logic [3:0]  vec;
        logic        exp;
    } eval_rec_t;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    function automatic int ones_below(input logic [15:0] tt, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(tt[i]);
        return s;
    endfunction

    task automatic do_load(input logic [15:0] tt);
        tt_data = tt; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic begin_sweep(input logic [15:0] tt, input bit with_load);
        tt_data = tt; load = with_load; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
    endtask

    // mode: 0 ready always, 1 ready toggles starting low, 2 random ready.
    // abort_after > 0 raises abort on the cycle of that accepted beat; inject drives load+start mid-sweep.
    task automatic run_sweep(input logic [15:0] tt, input int mode, input int abort_after,
                             input bit inject, output int beats, output int cycles, output bit saw_done);
        bit rdy;
        beats = 0; cycles = 0; saw_done = 0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin saw_done = 1; break; end
            if (!out_valid) break;
            cycles++;
            if (out_vec !== 4'(beats) || out_s !== tt[beats]) begin
                check($sformatf("beat%0d_vec", beats), int'(out_vec), beats);
                check($sformatf("beat%0d_s", beats), int'(out_s), int'(tt[beats]));
            end else begin
                checks++;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cycles % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            abort = (abort_after > 0 && rdy && beats == abort_after - 1);
            load  = inject && cycles == 5;
            start = inject && cycles == 5;
            tt_data = inject ? 16'h0000 : tt_data;
            @(negedge clk);
            if (rdy) beats++;
        end
        abort = 1'b0; load = 1'b0; start = 1'b0; out_ready = 1'b1;
        if (!saw_done && abort_after <= 0) check("sweep_timeout_or_early_end", beats, 16);
    endtask

    eval_rec_t evec [10];
    int beats, cycles;
    bit saw_done;
    logic [15:0] rtt;
    int rab;

    initial begin
        evec[0] = '{16'hAC3C, 4'hD, 1'b1};
        evec[1] = '{16'hAC3C, 4'h0, 1'b0};
        evec[2] = '{16'hAC3C, 4'h2, 1'b1};
        evec[3] = '{16'hFFFF, 4'h7, 1'b1};
        evec[4] = '{16'h0001, 4'h0, 1'b1};
        evec[5] = '{16'h0001, 4'h1, 1'b0};
        evec[6] = '{16'h8000, 4'hF, 1'b1};
        evec[7] = '{16'h8000, 4'hE, 1'b0};
        evec[8] = '{16'h1234, 4'h4, 1'b1};
        evec[9] = '{16'h5A5A, 4'h0, 1'b0};

        rst_n = 1'b0; load = 0; tt_data = 0; start = 0; abort = 0; out_ready = 1; eval_vec = 4'hD;
        #3;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_ones", int'(ones_cnt), 0);
        check("rst_eval_s", int'(eval_s), 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_table_eval_D", int'(eval_s), 1);

        // Default table, full-speed sweep
        begin_sweep(16'h0, 1'b0);
        check("first_beat_valid", int'(out_valid), 1);
        run_sweep(16'hAC3C, 0, 0, 0, beats, cycles, saw_done);
        check("default_sweep_cycles", cycles, 16);
        check("default_done", int'(saw_done), 1);
        check("default_done_busy", int'(busy), 1);
        check("default_done_valid", int'(out_valid), 0);
        check("default_ones", int'(ones_cnt), 8);
        @(negedge clk);
        check("after_done_busy", int'(busy), 0);
        check("after_done_pulse", int'(done), 0);
        check("idle_ones_hold", int'(ones_cnt), 8);

        // All-ones table with ready toggling
        do_load(16'hFFFF);
        begin_sweep(16'h0, 1'b0);
        run_sweep(16'hFFFF, 1, 0, 0, beats, cycles, saw_done);
        check("ffff_beats", beats, 16);
        check("ffff_cycles", cycles, 32);
        check("ffff_ones", int'(ones_cnt), 16);
        @(negedge clk);

        // Load and start together
        begin_sweep(16'h0001, 1'b1);
        run_sweep(16'h0001, 0, 0, 0, beats, cycles, saw_done);
        check("ls_same_ones", int'(ones_cnt), 1);
        check("ls_same_done", int'(saw_done), 1);
        @(negedge clk);

        // Abort after six accepted beats, then a load must be honoured
        do_load(16'hAC3C);
        begin_sweep(16'h0, 1'b0);
        run_sweep(16'hAC3C, 0, 6, 0, beats, cycles, saw_done);
        check("abort_beats", beats, 6);
        check("abort_no_done", int'(saw_done), 0);
        check("abort_idle", int'(busy), 0);
        check("abort_ones", int'(ones_cnt), 4);
        eval_vec = 4'h0;
        do_load(16'hFFFF);
        @(negedge clk);
        check("load_after_abort", int'(eval_s), 1);

        // Load/start during a sweep are ignored
        do_load(16'hAC3C);
        begin_sweep(16'h0, 1'b0);
        run_sweep(16'hAC3C, 0, 0, 1, beats, cycles, saw_done);
        check("inject_ones", int'(ones_cnt), 8);
        check("inject_done", int'(saw_done), 1);
        @(negedge clk);
        check("inject_idle", int'(busy), 0);

        // Table-driven single evaluation
        foreach (evec[i]) begin
            eval_vec = evec[i].vec;
            do_load(evec[i].tt);
            @(negedge clk);
            check($sformatf("eval_%04h_%0h", evec[i].tt, evec[i].vec), int'(eval_s), int'(evec[i].exp));
        end

        // Randomized sweeps against prefix-popcount model
        for (int r = 0; r < 20; r++) begin
            rtt = 16'($urandom);
            rab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : 0;
            begin_sweep(rtt, 1'b1);
            run_sweep(rtt, 2, rab, 0, beats, cycles, saw_done);
            check($sformatf("rand%0d_beats", r), beats, (rab > 0) ? rab : 16);
            check($sformatf("rand%0d_done", r), int'(saw_done), (rab > 0) ? 0 : 1);
            check($sformatf("rand%0d_ones", r), int'(ones_cnt), ones_below(rtt, beats));
            @(negedge clk);
        end

        // Asynchronous reset mid-sweep
        do_load(16'h0F0F);
        begin_sweep(16'h0, 1'b0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_vec", int'(out_vec), 0);
        check("mid_rst_s", int'(out_s), 0);
        check("mid_rst_ones", int'(ones_cnt), 0);
        check("mid_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1; eval_vec = 4'hD;
        @(negedge clk);
        check("post_rst_eval_D", int'(eval_s), 1);
        check("post_rst_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter N, default 4, number of function inputs; legal range 2..6.
REQ-002 Parameter TT_RESET, default 16'hAC3C truncated or zero-extended to 2^N bits, truth table loaded at reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  write tt_data into the table register.
REQ-006 tt_data  input  2^N  truth table; bit i is the function value for input pattern i.
REQ-007 start  input  1  begin a sweep of all 2^N patterns.
REQ-008 abort  input  1  terminate a running sweep.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 eval_vec  input  N  pattern for single evaluation.
REQ-011 busy  output  1  high while not IDLE.
REQ-012 out_valid  output  1  stream beat valid.
REQ-013 out_vec  output  N  pattern of the current beat.
REQ-014 out_s  output  1  function value for out_vec.
REQ-015 ones_cnt  output  N+1  count of accepted beats with out_s=1.
REQ-016 done  output  1  one-cycle pulse at sweep completion.
REQ-017 eval_s  output  1  registered function value for eval_vec.

Function
REQ-018 FSM states: IDLE, SWEEP, DONE.
REQ-019 IDLE->SWEEP on start; SWEEP->DONE after the beat with out_vec=2^N-1 is accepted; SWEEP->IDLE on abort; DONE->IDLE unconditionally after one cycle.
REQ-020 load is honoured only in IDLE; it is ignored in SWEEP and DONE, and the table does not change.
REQ-021 start is honoured only in IDLE; it is ignored in other states.
REQ-022 When load and start occur in the same IDLE cycle, the sweep uses the newly loaded table.
REQ-023 start clears ones_cnt to 0 and the pattern counter to 0.
REQ-024 In SWEEP, out_valid=1, out_vec=pattern counter, out_s=table[out_vec].
REQ-025 First beat appears the cycle after start is sampled.
REQ-026 Beat accepted when out_valid and out_ready are both 1 at a clock edge; the counter then increments by 1.
REQ-027 While out_ready=0, out_vec and out_s hold stable, and out_valid stays 1.
REQ-028 On each accepted beat with out_s=1, ones_cnt increments by 1.
REQ-029 ones_cnt never wraps; the maximum value is 2^N.
REQ-030 With continuous out_ready=1, a sweep lasts exactly 2^N cycles in SWEEP, followed by 1 cycle in DONE.
REQ-031 In DONE: done=1, out_valid=0, busy=1, and ones_cnt holds the final count.
REQ-032 ones_cnt holds its value in IDLE until the next start.
REQ-033 abort in SWEEP: state is IDLE the next cycle, out_valid=0, no done pulse, and ones_cnt holds the partial count.
REQ-034 abort in the same cycle as an accepted beat: the beat counts, then abort applies.
REQ-035 abort in IDLE or DONE has no effect.
REQ-036 out_valid is 0 and out_vec and out_s are 0 outside SWEEP.
REQ-037 eval_s = table[eval_vec] registered, with 1-cycle latency, in every state, independent of the sweep.

Reset
REQ-038 While rst_n=0, asynchronously: state=IDLE, table=TT_RESET, counter=0, ones_cnt=0, busy=0, out_valid=0, out_vec=0, out_s=0, done=0, eval_s=0.
REQ-039 Reset asserted mid-sweep forces all REQ-038 values immediately; no done pulse occurs.

Verification
REQ-040 N=4, post-reset, start, out_ready=1 -> out_s over patterns 0..15 = 0,0,1,1,1,1,0,0,0,0,1,1,0,1,0,1; done is pulsed in cycle 17 after start; ones_cnt=8.
REQ-041 load tt_data=16'hFFFF, then start, with out_ready toggling 1/0 every cycle -> 16 accepted beats, each held stable while stalled; ones_cnt=16; 32 SWEEP cycles.
REQ-042 load 16'h0001 and start in the same cycle -> only the pattern 0 beat has out_s=1; ones_cnt=1.
REQ-043 Default table, abort after 6 accepted beats -> IDLE next cycle, no done, ones_cnt=4; a subsequent load is accepted.
REQ-044 During a sweep, load 16'h0000 and start -> both ignored; sweep completes with ones_cnt=8.
REQ-045 rst_n low mid-sweep -> all outputs 0 at once; after release, eval_vec=4'hD gives eval_s=1 one cycle later (table=TT_RESET).
